// File: rtl/odd_parity_pkg.sv
// Shared types and helpers for the odd-parity generator/checker pair.
package odd_parity_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StHold
  } state_e;

  // Parity bit that makes the count of ones across the low `width` bits plus itself odd.
  function automatic logic odd_parity(input logic [31:0] vec, input int unsigned width);
    logic p;
    p = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        p = p ^ vec[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/odd_par_shift_acc.sv
// Data register, bit counter and running XOR accumulator for the odd-parity checker.
module odd_par_shift_acc
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o,
  output logic              acc_o,
  output logic              last_o
);

  localparam int unsigned BitCntW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  data_q, data_d;
  logic [BitCntW-1:0] cnt_q, cnt_d;
  logic               acc_q, acc_d;

  // load starts a new frame at bit 0; shift writes the bit at the current count.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    if (load_i) begin
      data_d[0] = bit_i;
      acc_d     = bit_i;
      cnt_d     = BitCntW'(1);
    end else if (shift_i) begin
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (cnt_q == BitCntW'(i)) begin
          data_d[i] = bit_i;
        end
      end
      acc_d = acc_q ^ bit_i;
      cnt_d = cnt_q + BitCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
    end
  end

  assign data_o = data_q;
  assign acc_o  = acc_q;
  assign last_o = (cnt_q == BitCntW'(DATA_W - 1));

endmodule

// File: rtl/odd_parity_checker.sv
// Serial odd-parity frame checker: reassembles DATA_W bits LSB first plus a parity bit.
// Define ODD_PAR_ERR_CNT_EN to add the saturating parity-error counter port err_cnt_o.
module odd_parity_checker
  import odd_parity_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bit_in_i,
  input  logic              bit_vld_i,
  input  logic              sof_i,
  output logic              bit_rdy_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic              par_err_o,
`ifdef ODD_PAR_ERR_CNT_EN
  output logic [CNT_W-1:0]  err_cnt_o,
`endif
  output logic              frame_err_o
);

  localparam state_e FirstState = (DATA_W == 1) ? StParity : StData;

  state_e state_q, state_d;
  logic   out_vld_q, out_vld_d;
  logic   par_err_q, par_err_d;
  logic   frame_err_q, frame_err_d;
  logic   accept;
  logic   sa_load, sa_shift;
  logic   sa_acc, sa_last;
  logic   err_inc;

  assign bit_rdy_o = ~rst_i & ((state_q != StHold) | out_rdy_i);
  assign accept    = bit_vld_i & bit_rdy_o;

  odd_par_shift_acc #(
    .DATA_W(DATA_W)
  ) u_shift_acc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (sa_load),
    .shift_i(sa_shift),
    .bit_i  (bit_in_i),
    .data_o (out_data_o),
    .acc_o  (sa_acc),
    .last_o (sa_last)
  );

  always_comb begin
    state_d     = state_q;
    out_vld_d   = out_vld_q;
    par_err_d   = par_err_q;
    frame_err_d = 1'b0;
    sa_load     = 1'b0;
    sa_shift    = 1'b0;
    err_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && sof_i) begin
          sa_load = 1'b1;
          state_d = FirstState;
        end
      end
      StData: begin
        if (accept && sof_i) begin
          sa_load     = 1'b1;
          frame_err_d = 1'b1;
          state_d     = FirstState;
        end else if (accept) begin
          sa_shift = 1'b1;
          if (sa_last) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        // sof on the parity slot aborts rather than closing the frame.
        if (accept && sof_i) begin
          sa_load     = 1'b1;
          frame_err_d = 1'b1;
          state_d     = FirstState;
        end else if (accept) begin
          out_vld_d = 1'b1;
          par_err_d = ~(sa_acc ^ bit_in_i);
          err_inc   = ~(sa_acc ^ bit_in_i);
          state_d   = StHold;
        end
      end
      StHold: begin
        if (out_rdy_i) begin
          out_vld_d = 1'b0;
          par_err_d = 1'b0;
          state_d   = StIdle;
          if (accept && sof_i) begin
            sa_load = 1'b1;
            state_d = FirstState;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      out_vld_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_vld_o   = out_vld_q;
  assign par_err_o   = par_err_q;
  assign frame_err_o = frame_err_q;

`ifdef ODD_PAR_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts on the same edge that raises out_vld, so the new value is visible with the word.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_cnt;
  assign unused_err_cnt = err_inc ^ (^CNT_W);
`endif

endmodule

// File: tb/tb_odd_parity_checker.sv
// Scoreboard bench for odd_parity_checker with DATA_W=8, CNT_W=2.
module tb_odd_parity_checker;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in, bit_vld, sof, out_rdy;
  logic       bit_rdy_o, out_vld_o, par_err_o, frame_err_o;
  logic [7:0] out_data_o;
`ifdef ODD_PAR_ERR_CNT_EN
  logic [1:0] err_cnt_o;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fe_seen  = 0;
  int   fe_exp   = 0;

  always #5 clk = ~clk;

  odd_parity_checker #(
    .DATA_W(8),
    .CNT_W (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bit_in_i   (bit_in),
    .bit_vld_i  (bit_vld),
    .sof_i      (sof),
    .bit_rdy_o  (bit_rdy_o),
    .out_data_o (out_data_o),
    .out_vld_o  (out_vld_o),
    .out_rdy_i  (out_rdy),
    .par_err_o  (par_err_o),
`ifdef ODD_PAR_ERR_CNT_EN
    .err_cnt_o  (err_cnt_o),
`endif
    .frame_err_o(frame_err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (!rst && frame_err_o) fe_seen++;
    if (!rst && out_vld_o && out_rdy) begin
      if (sb_q.size() == 0) begin
        check("spurious_word", 32'(sb_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("word_data", 32'(out_data_o), 32'(e.data));
        check("word_par_err", 32'(par_err_o), 32'(e.err));
`ifdef ODD_PAR_ERR_CNT_EN
        check("word_err_cnt", 32'(err_cnt_o), 32'(e.cnt));
`endif
      end
    end
  end

  // Entered and left at posedge+1; the bit is accepted on the edge in between.
  task automatic send_bit(input logic b, input logic s);
    int n;
    bit_in  = b;
    bit_vld = 1'b1;
    sof     = s;
    n       = 0;
    @(negedge clk);
    while (!bit_rdy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("bit_rdy_timeout", 32'(bit_rdy_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_vld = 1'b0;
    sof     = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic exp_err,
                            input int start, input bit gap, input int exp_cnt);
    exp_t e;
    for (int i = start; i < 8; i++) begin
      if (gap && i == 4) idle(3);
      send_bit(d[i], (i == 0));
    end
    check("pre_parity_vld", 32'(out_vld_o), 32'd0);
    e.data = d;
    e.err  = exp_err;
    e.cnt  = exp_cnt;
    sb_q.push_back(e);
    send_bit(p, 1'b0);
    check("latency_vld", 32'(out_vld_o), 32'd1);
    bit_vld = 1'b0;
  endtask

  initial begin
    logic [7:0] held_data;
    logic       held_err;
    int         n;
    rst     = 1'b1;
    bit_in  = 1'b0;
    bit_vld = 1'b0;
    sof     = 1'b0;
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bit_rdy", 32'(bit_rdy_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_vld", 32'(out_vld_o), 32'd0);
    check("reset_out_data", 32'(out_data_o), 32'd0);
    check("reset_par_err", 32'(par_err_o), 32'd0);
    check("reset_frame_err", 32'(frame_err_o), 32'd0);
    check("reset_bit_rdy", 32'(bit_rdy_o), 32'd1);
`ifdef ODD_PAR_ERR_CNT_EN
    check("reset_err_cnt", 32'(err_cnt_o), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Stray bit without sof in IDLE is dropped.
    send_bit(1'b1, 1'b0);
    idle(1);

    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0, 0);
    idle(1);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b1, 1);
    idle(1);

    // Early sof aborts a 3-bit partial frame.
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    fe_exp++;
    check("abort_frame_err", 32'(frame_err_o), 32'd1);
    send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b0, 1);
    idle(1);

    // Backpressure in HOLD, released together with the next frame's sof bit.
    out_rdy = 1'b0;
    send_frame(8'h96, 1'b0, 1'b1, 0, 1'b0, 2);
    held_data = out_data_o;
    held_err  = par_err_o;
    bit_in    = 1'b1;
    bit_vld   = 1'b1;
    sof       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_bit_rdy", 32'(bit_rdy_o), 32'd0);
      check("hold_out_vld", 32'(out_vld_o), 32'd1);
      check("hold_out_data", 32'(out_data_o), 32'(held_data));
      check("hold_par_err", 32'(par_err_o), 32'(held_err));
      @(posedge clk);
      #1;
    end
    check("hold_data_value", 32'(held_data), 32'h96);
    out_rdy = 1'b1;
    send_bit(1'b1, 1'b1);
    check("release_out_vld", 32'(out_vld_o), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0, 1, 1'b0, 2);
    idle(1);

    // Reset mid-frame discards the partial word.
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    bit_vld = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("midrst_bit_rdy", 32'(bit_rdy_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_vld", 32'(out_vld_o), 32'd0);
    check("midrst_out_data", 32'(out_data_o), 32'd0);
    check("midrst_par_err", 32'(par_err_o), 32'd0);
    @(posedge clk);
    #1;
    send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b0, 0);
    idle(1);

    // Five bad-parity frames drive the 2-bit counter into saturation.
    send_frame(8'h00, 1'b0, 1'b1, 0, 1'b0, 1);
    send_frame(8'h03, 1'b0, 1'b1, 0, 1'b0, 2);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0, 3);
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0, 3);
    send_frame(8'h7E, 1'b0, 1'b1, 0, 1'b0, 3);
    idle(2);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("words_drained", 32'(sb_q.size()), 32'd0);
    check("frame_err_count", 32'(fe_seen), 32'(fe_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
